// File: rtl/raster_scanner.sv
// Raster-scan address generator: walks (x,y) over an H_COUNT x V_COUNT grid,
// advancing one pixel per valid/ready handshake. Supports single-frame and
// continuous operation, line/frame markers and a wrapping frame counter.
module raster_scanner #(
    parameter int H_COUNT = 16,
    parameter int V_COUNT = 16,
    parameter int X_W     = $clog2(H_COUNT > 1 ? H_COUNT : 2),
    parameter int Y_W     = $clog2(V_COUNT > 1 ? V_COUNT : 2),
    parameter int FRAME_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               clear,
    input  logic               continuous,
    input  logic               pix_ready,
    output logic               pix_valid,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic               line_end,
    output logic               frame_end,
    output logic               busy,
    output logic               done,
    output logic [FRAME_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [X_W-1:0]     X_LAST    = X_W'(H_COUNT - 1);
    localparam logic [Y_W-1:0]     Y_LAST    = Y_W'(V_COUNT - 1);
    localparam logic [X_W-1:0]     X_ZERO    = {X_W{1'b0}};
    localparam logic [Y_W-1:0]     Y_ZERO    = {Y_W{1'b0}};
    localparam logic [X_W-1:0]     X_ONE     = X_W'(1);
    localparam logic [Y_W-1:0]     Y_ONE     = Y_W'(1);
    localparam logic [FRAME_W-1:0] FRAME_ZERO = {FRAME_W{1'b0}};
    localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);

    state_t             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    logic               last_col_s;
    logic               last_row_s;
    logic               valid_s;

    // Decode the registered state into status flags and position markers.
    always_comb begin
        valid_s    = (state_q == ST_SCAN);
        // >= rather than == so a corrupted coordinate can never run past the grid.
        last_col_s = (x_q >= X_LAST);
        last_row_s = (y_q >= Y_LAST);
    end

    // Next-state computation: clear aborts from anywhere, otherwise the FSM
    // advances the raster position on each accepted pixel.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        frame_d = frame_q;
        if (clear) begin
            state_d = ST_IDLE;
            x_d     = X_ZERO;
            y_d     = Y_ZERO;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_SCAN;
                        x_d     = X_ZERO;
                        y_d     = Y_ZERO;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_SCAN: begin
                    if (pix_ready) begin
                        if (!last_col_s) begin
                            x_d = x_q + X_ONE;
                        end else if (!last_row_s) begin
                            x_d = X_ZERO;
                            y_d = y_q + Y_ONE;
                        end else begin
                            // Last pixel of the frame: count it and either
                            // roll straight into the next frame or stop.
                            x_d     = X_ZERO;
                            y_d     = Y_ZERO;
                            frame_d = frame_q + FRAME_ONE;
                            state_d = continuous ? ST_SCAN : ST_DONE;
                        end
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    x_d     = X_ZERO;
                    y_d     = Y_ZERO;
                end
            endcase
        end
    end

    // State, position and frame-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= X_ZERO;
            y_q     <= Y_ZERO;
            frame_q <= FRAME_ZERO;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
        end
    end

    // Drive outputs straight from the registers.
    always_comb begin
        pix_valid = valid_s;
        x         = x_q;
        y         = y_q;
        line_end  = valid_s & (x_q == X_LAST);
        frame_end = valid_s & (x_q == X_LAST) & (y_q == Y_LAST);
        busy      = valid_s;
        done      = (state_q == ST_DONE);
        frame_cnt = frame_q;
    end

endmodule

// File: tb/tb_raster_scanner.sv
// Self-checking bench for raster_scanner: a 4x3 instance (2-bit frame counter)
// and a 5x1 instance share stimulus; each is tracked by a linear-pixel-index
// reference model, plus a hand-computed vector table and corner sequences.
module tb_raster_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, start = 1'b0, clear = 1'b0, continuous = 1'b0, pix_ready = 1'b0;

    // DUT A: 4 x 3, FRAME_W=2
    logic       a_valid, a_le, a_fe, a_busy, a_done;
    logic [1:0] a_x, a_y, a_fc;
    // DUT B: 5 x 1, FRAME_W=2
    logic       b_valid, b_le, b_fe, b_busy, b_done;
    logic [2:0] b_x;
    logic [0:0] b_y;
    logic [1:0] b_fc;

    raster_scanner #(.H_COUNT(4), .V_COUNT(3), .FRAME_W(2)) dut_a (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .continuous(continuous), .pix_ready(pix_ready),
        .pix_valid(a_valid), .x(a_x), .y(a_y), .line_end(a_le),
        .frame_end(a_fe), .busy(a_busy), .done(a_done), .frame_cnt(a_fc)
    );

    raster_scanner #(.H_COUNT(5), .V_COUNT(1), .FRAME_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .continuous(continuous), .pix_ready(pix_ready),
        .pix_valid(b_valid), .x(b_x), .y(b_y), .line_end(b_le),
        .frame_end(b_fe), .busy(b_busy), .done(b_done), .frame_cnt(b_fc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode 0=idle 1=scanning 2=finished; p = linear pixel index.
    int m_mode [2];
    int m_p    [2];
    int m_fr   [2];
    int m_h    [2] = '{4, 5};
    int m_v    [2] = '{3, 1};

    int a_le_seen, a_fe_seen, b_le_seen, b_fe_seen;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    function automatic void model_step(input int d, input bit r, input bit s,
                                       input bit c, input bit co, input bit rdy);
        if (r) begin
            m_mode[d] = 0; m_p[d] = 0; m_fr[d] = 0;
        end else if (c) begin
            m_mode[d] = 0; m_p[d] = 0;
        end else if (m_mode[d] == 1) begin
            if (rdy) begin
                if (m_p[d] == m_h[d] * m_v[d] - 1) begin
                    m_p[d]    = 0;
                    m_fr[d]   = (m_fr[d] + 1) % 4;
                    m_mode[d] = co ? 1 : 2;
                end else begin
                    m_p[d] = m_p[d] + 1;
                end
            end
        end else if (s) begin
            m_mode[d] = 1; m_p[d] = 0;
        end
    endfunction

    task automatic check_dut(input int d, input string tag, input int pv, input int xx,
                             input int yy, input int le, input int fe, input int bz,
                             input int dn, input int fc);
        int ev;
        ev = (m_mode[d] == 1) ? 1 : 0;
        chk({tag, ".pix_valid"}, pv, ev);
        chk({tag, ".x"}, xx, m_p[d] % m_h[d]);
        chk({tag, ".y"}, yy, m_p[d] / m_h[d]);
        chk({tag, ".line_end"}, le, (ev == 1 && (m_p[d] % m_h[d]) == m_h[d] - 1) ? 1 : 0);
        chk({tag, ".frame_end"}, fe, (ev == 1 && m_p[d] == m_h[d] * m_v[d] - 1) ? 1 : 0);
        chk({tag, ".busy"}, bz, ev);
        chk({tag, ".done"}, dn, (m_mode[d] == 2) ? 1 : 0);
        chk({tag, ".frame_cnt"}, fc, m_fr[d]);
    endtask

    // Apply one cycle of inputs, advance the models, then compare both DUTs.
    task automatic cycle(input bit r, input bit s, input bit c, input bit co, input bit rdy);
        reset = r; start = s; clear = c; continuous = co; pix_ready = rdy;
        model_step(0, r, s, c, co, rdy);
        model_step(1, r, s, c, co, rdy);
        @(posedge clk);
        #1;
        check_dut(0, "A", int'(a_valid), int'(a_x), int'(a_y), int'(a_le), int'(a_fe),
                  int'(a_busy), int'(a_done), int'(a_fc));
        check_dut(1, "B", int'(b_valid), int'(b_x), int'(b_y), int'(b_le), int'(b_fe),
                  int'(b_busy), int'(b_done), int'(b_fc));
        if (a_le) a_le_seen++;
        if (a_fe) a_fe_seen++;
        if (b_le) b_le_seen++;
        if (b_fe) b_fe_seen++;
        chk("B.x_in_range", (int'(b_x) <= 4) ? 1 : 0, 1);
    endtask

    typedef struct {
        bit r, s, c, co, rdy;
        int ev, ex, ey, ele, efe, ebusy, edone, efc;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // Hand-computed expectations for DUT A after each row's clock edge.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 0, 1, 0, 0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0, 0, 0, 1, 0, 0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 2, 0, 0, 0, 1, 0, 0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 2, 0, 0, 0, 1, 0, 0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 3, 0, 1, 0, 1, 0, 0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 0, 1, 0, 0};

        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_p[d] = 0; m_fr[d] = 0;
        end
        @(posedge clk);
        #1;

        // Table-driven vectors (also clear+start at (3,0) -> IDLE).
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].r, vecs[i].s, vecs[i].c, vecs[i].co, vecs[i].rdy);
            chk("tbl.pix_valid", int'(a_valid), vecs[i].ev);
            chk("tbl.x", int'(a_x), vecs[i].ex);
            chk("tbl.y", int'(a_y), vecs[i].ey);
            chk("tbl.line_end", int'(a_le), vecs[i].ele);
            chk("tbl.frame_end", int'(a_fe), vecs[i].efe);
            chk("tbl.busy", int'(a_busy), vecs[i].ebusy);
            chk("tbl.done", int'(a_done), vecs[i].edone);
            chk("tbl.frame_cnt", int'(a_fc), vecs[i].efc);
        end

        // Single frame: 12 accepts, markers counted over displayed pixels.
        cycle(1, 0, 0, 0, 0);
        a_le_seen = 0; a_fe_seen = 0;
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 11; i++) cycle(0, 0, 0, 0, 1);
        chk("frame.last_x", int'(a_x), 3);
        chk("frame.last_y", int'(a_y), 2);
        chk("frame.last_fe", int'(a_fe), 1);
        cycle(0, 0, 0, 0, 1);
        chk("frame.line_end_count", a_le_seen, 3);
        chk("frame.frame_end_count", a_fe_seen, 1);
        chk("frame.done", int'(a_done), 1);
        chk("frame.frame_cnt", int'(a_fc), 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        chk("done.held", int'(a_done), 1);
        cycle(0, 1, 0, 0, 0);
        chk("done_start.valid", int'(a_valid), 1);
        chk("done_start.xy", int'(a_x) + int'(a_y), 0);

        // Stall at (1,1) for 5 cycles, then resume to (2,1).
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 0);
            chk("stall.x", int'(a_x), 1);
            chk("stall.y", int'(a_y), 1);
            chk("stall.valid", int'(a_valid), 1);
        end
        cycle(0, 0, 0, 0, 1);
        chk("resume.x", int'(a_x), 2);
        chk("resume.y", int'(a_y), 1);

        // Clear from SCAN keeps the frame counter.
        cycle(0, 0, 1, 0, 0);
        chk("clear.valid", int'(a_valid), 0);
        chk("clear.frame_cnt", int'(a_fc), 1);

        // Continuous: 5 frames, no bubble, counter wraps through 0.
        b_le_seen = 0; b_fe_seen = 0;
        cycle(0, 1, 0, 1, 0);
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, 1);
            chk("cont.valid", int'(a_valid), 1);
            chk("cont.x", int'(a_x), 0);
            chk("cont.y", int'(a_y), 0);
            chk("cont.frame_cnt", int'(a_fc), (f + 2) % 4);
        end
        chk("B.le_eq_fe", b_le_seen, b_fe_seen);
        chk("B.le_count", b_le_seen, 60 / 5);

        // Reset mid-scan at (2,1).
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 1);
        chk("pre_reset.x", int'(a_x), 2);
        chk("pre_reset.y", int'(a_y), 1);
        cycle(1, 1, 0, 1, 1);
        chk("reset.valid", int'(a_valid), 0);
        chk("reset.x", int'(a_x), 0);
        chk("reset.y", int'(a_y), 0);
        chk("reset.frame_cnt", int'(a_fc), 0);

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(63) == 0), ($urandom_range(7) == 0),
                  ($urandom_range(31) == 0), $urandom_range(1) == 1,
                  ($urandom_range(3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
